// File: rtl/aes_round_controller.sv
// aes_round_controller: iterative AES-128 encryptor, one round per clock, with on-the-fly key expansion
module sub_bytes (
  input  logic [127:0] stateIn,
  output logic [127:0] stateOut
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // Multiplicative inverse as a^254 (0 maps to 0), then the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), a);
    r = gmul(r, r);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  for (genvar g = 0; g < 16; g++) begin : gByte
    assign stateOut[8*g +: 8] = sbox(stateIn[8*g +: 8]);
  end
endmodule

module shift_rows (
  input  logic [127:0] stateIn,
  output logic [127:0] stateOut
);
  for (genvar c = 0; c < 4; c++) begin : gCol
    for (genvar r = 0; r < 4; r++) begin : gRow
      assign stateOut[127-8*(4*c+r) -: 8] = stateIn[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end
endmodule

module mix_columns (
  input  logic [127:0] stateIn,
  output logic [127:0] stateOut
);
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  for (genvar c = 0; c < 4; c++) begin : gCol
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = stateIn[127-32*c -: 32];
    assign stateOut[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                       a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                       a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                       xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  end
endmodule

module aes_round_controller (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic [3:0]   round
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsmT;
  fsmT fsm, nextFsm;
  logic [127:0] stateReg, keyReg, cipherReg, sbOut, srOut, mixOut, subWordOut, nextKey;
  logic [31:0] w3, t, n0, n1, n2;
  logic [3:0] roundReg;
  logic unusedSub;
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1: return 8'h01;
      4'd2: return 8'h02;
      4'd3: return 8'h04;
      4'd4: return 8'h08;
      4'd5: return 8'h10;
      4'd6: return 8'h20;
      4'd7: return 8'h40;
      4'd8: return 8'h80;
      4'd9: return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction
  sub_bytes uSub (.stateIn(stateReg), .stateOut(sbOut));
  shift_rows uShift (.stateIn(sbOut), .stateOut(srOut));
  mix_columns uMix (.stateIn(srOut), .stateOut(mixOut));
  // SubWord reuses a full sub_bytes; only the top word carries the rotated w3
  assign w3 = keyReg[31:0];
  sub_bytes uSubWord (.stateIn({w3[23:0], w3[31:24], 96'h0}), .stateOut(subWordOut));
  assign unusedSub = ^subWordOut[95:0];
  assign t = subWordOut[127:96] ^ {rcon(roundReg), 24'h0};
  assign n0 = keyReg[127:96] ^ t;
  assign n1 = keyReg[95:64] ^ n0;
  assign n2 = keyReg[63:32] ^ n1;
  assign nextKey = {n0, n1, n2, w3 ^ n2};
  assign in_ready = fsm == IDLE;
  assign busy = fsm != IDLE;
  assign out_valid = fsm == DONE;
  assign round = roundReg;
  assign ciphertext = cipherReg;
  always_comb begin
    nextFsm = fsm;
    case (fsm)
      IDLE: nextFsm = in_valid ? ROUND : IDLE;
      ROUND: nextFsm = roundReg == 4'd9 ? FINAL : ROUND;
      FINAL: nextFsm = DONE;
      DONE: nextFsm = out_ready ? IDLE : DONE;
      default: nextFsm = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm <= IDLE;
      stateReg <= '0;
      keyReg <= '0;
      cipherReg <= '0;
      roundReg <= '0;
    end else begin
      fsm <= nextFsm;
      case (fsm)
        IDLE: if (in_valid) begin
          stateReg <= plaintext ^ key;
          keyReg <= key;
          roundReg <= 4'd1;
        end
        ROUND: begin
          stateReg <= mixOut ^ nextKey;
          keyReg <= nextKey;
          roundReg <= roundReg + 4'd1;
        end
        FINAL: begin
          stateReg <= srOut ^ nextKey;
          cipherReg <= srOut ^ nextKey;
          keyReg <= nextKey;
        end
        DONE: if (out_ready) roundReg <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_round_controller.sv
// tb_aes_round_controller: directed FIPS-197 vectors, backpressure, busy rejection, reset and back-to-back issue
module tb_aes_round_controller;
  logic clk = 0, rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] plaintext, key, ciphertext;
  logic [3:0] round;
  int total = 0, passed = 0, cyc = 0, n;
  int acc[$];
  logic [127:0] res[$];
  localparam logic [127:0] PB = 128'h3243F6A8885A308D313198A2E0370734;
  localparam logic [127:0] KB = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] CB = 128'h3925841D02DC09FBDC118597196A0B32;
  localparam logic [127:0] PC = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] KC = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] CC = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
  aes_round_controller dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .ciphertext(ciphertext), .busy(busy), .round(round));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  initial begin
    rst = 1; in_valid = 0; out_ready = 0; plaintext = '0; key = '0;
    @(negedge clk); @(negedge clk);
    rst = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_round", round, 0);
    chk("rst_cipher", ciphertext, 0);
    // App. B with a rejected C.1 pulse at round 4, then backpressure
    plaintext = PB; key = KB; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    chk("b_round1", round, 1);
    chk("b_in_ready", in_ready, 0);
    chk("b_busy", busy, 1);
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      in_valid = 0;
      chk($sformatf("b_round%0d", k), round, k);
      chk($sformatf("b_noval%0d", k), out_valid, 0);
      if (k == 4) begin
        in_valid = 1; plaintext = PC; key = KC;
      end
    end
    @(negedge clk);
    chk("b_out_valid", out_valid, 1);
    chk("b_cipher", ciphertext, CB);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_cipher", ciphertext, CB);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_busy", busy, 1);
    end
    out_ready = 1;
    @(negedge clk);
    chk("bp_idle_in_ready", in_ready, 1);
    chk("bp_idle_valid", out_valid, 0);
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_round", round, 0);
    chk("bp_idle_cipher", ciphertext, CB);
    // C.1 interrupted by reset at round 5
    plaintext = PC; key = KC; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (4) @(negedge clk);
    chk("r_round5", round, 5);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("r_round", round, 0);
    chk("r_in_ready", in_ready, 1);
    chk("r_out_valid", out_valid, 0);
    chk("r_cipher", ciphertext, 0);
    chk("r_busy", busy, 0);
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("c_latency", n, 10);
    chk("c_cipher", ciphertext, CC);
    // Back-to-back with in_valid held high
    plaintext = PB; key = KB; in_valid = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) res.push_back(ciphertext);
      if (acc.size() == 1 && busy) begin
        plaintext = PC; key = KC;
      end
      if (acc.size() == 2 && busy) in_valid = 0;
      if (in_ready && in_valid) acc.push_back(cyc);
    end
    chk("bb_accepts", acc.size(), 2);
    chk("bb_interval", acc.size() == 2 ? acc[1] - acc[0] : -1, 12);
    chk("bb_results", res.size(), 2);
    chk("bb_cipher0", res.size() > 0 ? res[0] : 'x, CB);
    chk("bb_cipher1", res.size() > 1 ? res[1] : 'x, CC);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/aes_round_controller.md
# aes_round_controller

Iterative AES-128 encryption engine: accepts a 128-bit plaintext and cipher key, runs the initial AddRoundKey plus 10 rounds at one round per clock, and returns the ciphertext over a valid/ready handshake. It owns the state register, round counter, round-constant generation and on-the-fly key expansion. It sequences the existing combinational `sub_bytes`, `shift_rows` and `mix_columns` blocks, bypassing `mix_columns` on the final round. It sits between the host-facing input buffer and the output buffer of the AES top level.

## Interface
Parameters: none. AES-128 only.

- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  plaintext/key pair presented
- in_ready  output  1  block can accept a pair; high only in IDLE
- plaintext  input  128  column-major, byte 0 = [127:120], column 0 = [127:96] (same ordering as `mix_columns`)
- key  input  128  cipher key, same byte ordering
- out_valid  output  1  ciphertext valid; held until accepted
- out_ready  input  1  downstream accepts ciphertext
- ciphertext  output  128  result, same byte ordering
- busy  output  1  high in ROUND, FINAL and DONE
- round  output  4  current round number (0 in IDLE; 1–10 while running)

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE: in_ready=1. If in_valid at the edge, then state_reg <= plaintext ^ key, key_reg <= key, round <= 1, go to ROUND. in_valid is ignored in every other state, and inputs are sampled only on the accept edge.
- ROUND (rounds 1–9):
  - next_key = expand(key_reg, rcon[round]).
  - state_reg <= mix_columns(shift_rows(sub_bytes(state_reg))) ^ next_key.
  - key_reg <= next_key, round <= round+1.
  - At round 9, go to FINAL.
- FINAL (round 10):
  - state_reg <= shift_rows(sub_bytes(state_reg)) ^ next_key, with no mix_columns.
  - ciphertext register loaded with the same value; go to DONE.
- DONE: out_valid=1 and ciphertext is held stable. When out_ready=1 at the edge, go to IDLE and round <= 0. A new pair cannot be accepted on that same edge, so there is a one-cycle bubble.
- Key expansion, with words w0..w3 = key_reg[127:96]..[31:0]:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
  - RotWord rotates left by one byte.
  - SubWord uses a second `sub_bytes` instance with the word in [127:96] and zeros elsewhere. Only [127:96] of its output is used.
- rcon for rounds 1..10: 01,02,04,08,10,20,40,80,1B,36. Any other round value gives rcon 00, which is unreachable.
- out_ready while out_valid=0 is ignored.
- Reset (any state, including mid-round): state IDLE, round=0, out_valid=0, busy=0, in_ready=1 after the reset edge. ciphertext, state_reg and key_reg are cleared to 0. Any in-flight operation is discarded with no output.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, round=0, ciphertext=128'h0.
- Accept on edge E0. ROUND occupies the cycles after edges E0..E8, FINAL follows E9, and out_valid rises after edge E10. Latency from accept edge to out_valid is 10 cycles.
- Minimum issue interval is 12 cycles: 10 processing cycles, 1 DONE cycle and 1 IDLE cycle.
- All outputs are registered or decoded from state. There are no combinational paths from inputs to outputs.
- ciphertext changes only on the FINAL→DONE edge and on reset.

## Test plan
- **FIPS-197 App. B.** plaintext 3243F6A8885A308D313198A2E0370734, key 2B7E151628AED2A6ABF7158809CF4F3C, out_ready=1 → out_valid exactly 10 cycles after accept, ciphertext 3925841D02DC09FBDC118597196A0B32. Check round steps 1..10.
- **FIPS-197 App. C.1.** plaintext 00112233445566778899AABBCCDDEEFF, key 000102030405060708090A0B0C0D0E0F → ciphertext 69C4E0D86A7B0430D8CDB78070B4C55A.
- **Backpressure.** Hold out_ready=0 for 5 cycles after out_valid → out_valid and ciphertext remain stable, in_ready stays 0 and busy stays 1. Raise out_ready → IDLE the next cycle.
- **Busy rejection.** Pulse in_valid with the C.1 data at round 4 of the App. B run → App. B result is unaffected, and the second pair is not processed.
- **Reset mid-operation.** Assert rst for one cycle at round 5 → the next cycle shows round=0, in_ready=1, out_valid=0, ciphertext=0. A fresh C.1 run then yields the correct ciphertext.
- **Back-to-back.** Drive App. B then C.1 with in_valid held high and out_ready=1 → two correct results, with accept edges exactly 12 cycles apart.
